// File: rtl/test_mode_param.sv
// test_mode_param: scalable test-mode micro benchmark.
//
// Two serial inputs run through PIPE_DEPTH-deep shift pipelines. Their taps feed
// a RING_WIDTH-bit registered feedback adder ring. A runtime mode selects what
// the ring register does on each edge: ring-sum, hold, LFSR shift or count.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset (0 = reset asserted)
//   a, b       serial inputs
//   mode       00 ring, 01 hold, 10 lfsr, 11 count; sampled every edge
//   out        ring register ps
//   out_valid  high once both input pipelines have filled; stays high until reset
//   ovf        registered overflow/carry flag; valid for one edge, not sticky
module test_mode_param #(
  parameter int unsigned PIPE_DEPTH = 2,
  parameter int unsigned RING_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a,
  input  logic                  b,
  input  logic [1:0]            mode,
  output logic [RING_WIDTH-1:0] out,
  output logic                  out_valid,
  output logic                  ovf
);

  localparam int unsigned FillW = $clog2(PIPE_DEPTH + 1);

  localparam logic [1:0] ModeRing  = 2'b00;
  localparam logic [1:0] ModeHold  = 2'b01;
  localparam logic [1:0] ModeLfsr  = 2'b10;
  localparam logic [1:0] ModeCount = 2'b11;

  logic [PIPE_DEPTH-1:0] pipe_a_q, pipe_a_d;
  logic [PIPE_DEPTH-1:0] pipe_b_q, pipe_b_d;
  logic [FillW-1:0]      fill_q, fill_d;
  logic [RING_WIDTH-1:0] ps_q, ps_d;
  logic                  ovf_q, ovf_d;

  logic                  pa, pb;
  logic [RING_WIDTH-1:0] ps_next;
  logic [RING_WIDTH-1:0] carry;
  logic [1:0]            stage_sum;

  assign pa = pipe_a_q[PIPE_DEPTH-1];
  assign pb = pipe_b_q[PIPE_DEPTH-1];

  // Input pipelines and fill counter advance on every edge, regardless of mode.
  always_comb begin
    pipe_a_d    = '0;
    pipe_b_d    = '0;
    pipe_a_d[0] = a;
    pipe_b_d[0] = b;
    for (int i = 1; i < int'(PIPE_DEPTH); i++) begin
      pipe_a_d[i] = pipe_a_q[i-1];
      pipe_b_d[i] = pipe_b_q[i-1];
    end
    fill_d = fill_q;
    if (fill_q != FillW'(PIPE_DEPTH)) begin
      fill_d = fill_q + FillW'(1);
    end
  end

  // Ripple ring: each stage is a 2-bit sum of three bits. Stage 0 takes the taps
  // plus the ring's top bit; stage k takes the previous bit, the previous carry
  // and its other neighbour (wrapping to bit 0 for the top stage).
  always_comb begin
    ps_next   = '0;
    carry     = '0;
    stage_sum = {1'b0, pa} + {1'b0, pb} + {1'b0, ps_q[RING_WIDTH-1]};
    ps_next[0] = stage_sum[0];
    carry[0]   = stage_sum[1];
    for (int k = 1; k < int'(RING_WIDTH); k++) begin
      stage_sum  = {1'b0, ps_q[k-1]} + {1'b0, carry[k-1]}
                 + {1'b0, ps_q[(k + 1) % int'(RING_WIDTH)]};
      ps_next[k] = stage_sum[0];
      carry[k]   = stage_sum[1];
    end
  end

  always_comb begin
    ps_d  = ps_q;
    ovf_d = 1'b0;
    unique case (mode)
      ModeRing: begin
        ps_d  = ps_next;
        ovf_d = carry[RING_WIDTH-1];
      end
      ModeHold: begin
        ps_d = ps_q;
      end
      ModeLfsr: begin
        ps_d = {ps_q[RING_WIDTH-2:0], pa ^ ps_q[RING_WIDTH-1]};
      end
      ModeCount: begin
        ps_d  = ps_q + RING_WIDTH'(1);
        ovf_d = &ps_q;  // wrap from all-ones to zero
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_a_q <= '0;
      pipe_b_q <= '0;
      fill_q   <= '0;
      ps_q     <= '0;
      ovf_q    <= 1'b0;
    end else begin
      pipe_a_q <= pipe_a_d;
      pipe_b_q <= pipe_b_d;
      fill_q   <= fill_d;
      ps_q     <= ps_d;
      ovf_q    <= ovf_d;
    end
  end

  assign out       = ps_q;
  assign out_valid = (fill_q == FillW'(PIPE_DEPTH));
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_test_mode_param.sv
// Self-checking bench for test_mode_param: directed vectors on the default
// configuration plus a reference-model sweep over two other parameter sets.
module tb_test_mode_param;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       a = 1'b0;
  logic       b = 1'b0;
  logic [1:0] mode = 2'b00;

  logic [3:0] out0;
  logic       valid0, ovf0;
  logic [1:0] out1;
  logic       valid1, ovf1;
  logic [7:0] out2;
  logic       valid2, ovf2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  test_mode_param u_dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .mode(mode),
    .out(out0), .out_valid(valid0), .ovf(ovf0)
  );

  test_mode_param #(.PIPE_DEPTH(1), .RING_WIDTH(2)) u_dut_p1w2 (
    .clk(clk), .reset(reset), .a(a), .b(b), .mode(mode),
    .out(out1), .out_valid(valid1), .ovf(ovf1)
  );

  test_mode_param #(.PIPE_DEPTH(5), .RING_WIDTH(8)) u_dut_p5w8 (
    .clk(clk), .reset(reset), .a(a), .b(b), .mode(mode),
    .out(out2), .out_valid(valid2), .ovf(ovf2)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state (widths up to 8).
  typedef struct packed {
    logic [7:0] sa;
    logic [7:0] sb;
    logic [7:0] ps;
    logic       ovf;
    logic [3:0] fill;
  } mstate_t;

  function automatic mstate_t mstep(mstate_t s, int pd, int w, logic ia, logic ib,
                                    logic [1:0] md);
    mstate_t    n;
    logic       ta, tb;
    logic [7:0] mask;
    int         c;
    int         sum;
    n    = s;
    ta   = s.sa[pd-1];
    tb   = s.sb[pd-1];
    mask = 8'((1 << w) - 1);
    n.sa = {s.sa[6:0], ia};
    n.sb = {s.sb[6:0], ib};
    if (int'(s.fill) < pd) n.fill = s.fill + 4'd1;
    n.ovf = 1'b0;
    case (md)
      2'b00: begin
        n.ps = '0;
        sum  = int'(ta) + int'(tb) + int'(s.ps[w-1]);
        n.ps[0] = sum[0];
        c = sum / 2;
        for (int k = 1; k < w; k++) begin
          sum = int'(s.ps[k-1]) + c + int'(s.ps[(k + 1) % w]);
          n.ps[k] = sum[0];
          c = sum / 2;
        end
        n.ovf = (c != 0);
      end
      2'b01: n.ps = s.ps;
      2'b10: n.ps = ((s.ps << 1) | {7'd0, ta ^ s.ps[w-1]}) & mask;
      default: begin
        n.ovf = (s.ps == mask);
        n.ps  = (s.ps + 8'd1) & mask;
      end
    endcase
    return n;
  endfunction

  mstate_t m0, m1, m2;

  // Hold reset for two edges with the given inputs, release mid-cycle.
  task automatic do_reset(input logic ia, input logic ib, input logic [1:0] md);
    a     = ia;
    b     = ib;
    mode  = md;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    m0 = '0;
    m1 = '0;
    m2 = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] lfsr_exp [7];
  logic [3:0] ring_exp [3];

  initial begin
    // Reset and fill.
    a = 1'b0; b = 1'b0; mode = 2'b00; reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_out", 32'(out0), 32'h0);
    check_val("rst_valid", 32'(valid0), 32'h0);
    check_val("rst_ovf", 32'(ovf0), 32'h0);
    reset = 1'b1;
    tick();
    check_val("fill_e1_valid", 32'(valid0), 32'h0);
    check_val("fill_e1_out", 32'(out0), 32'h0);
    tick();
    check_val("fill_e2_valid", 32'(valid0), 32'h1);
    check_val("fill_e2_ovf", 32'(ovf0), 32'h0);
    tick();
    check_val("fill_e3_valid", 32'(valid0), 32'h1);

    // Ring with a=1, b=0.
    ring_exp[0] = 4'h1; ring_exp[1] = 4'hB; ring_exp[2] = 4'h4;
    do_reset(1'b1, 1'b0, 2'b00);
    tick(); tick();
    for (int e = 0; e < 3; e++) begin
      tick();
      check_val($sformatf("ring_e%0d_out", e + 3), 32'(out0), 32'(ring_exp[e]));
      check_val($sformatf("ring_e%0d_ovf", e + 3), 32'(ovf0), (e == 2) ? 32'h1 : 32'h0);
    end
    // Async reset while ovf=1.
    #2 reset = 1'b0;
    #1;
    check_val("async1_out", 32'(out0), 32'h0);
    check_val("async1_ovf", 32'(ovf0), 32'h0);
    check_val("async1_valid", 32'(valid0), 32'h0);

    // Hold, then async reset.
    do_reset(1'b1, 1'b0, 2'b00);
    repeat (4) tick();
    check_val("hold_pre_out", 32'(out0), 32'hB);
    mode = 2'b01;
    for (int e = 0; e < 5; e++) begin
      tick();
      check_val($sformatf("hold_%0d_out", e), 32'(out0), 32'hB);
      check_val($sformatf("hold_%0d_ovf", e), 32'(ovf0), 32'h0);
    end
    #2 reset = 1'b0;
    #1;
    check_val("async2_out", 32'(out0), 32'h0);
    check_val("async2_ovf", 32'(ovf0), 32'h0);
    check_val("async2_valid", 32'(valid0), 32'h0);

    // Counter wrap.
    do_reset(1'b0, 1'b0, 2'b11);
    for (int e = 1; e <= 16; e++) begin
      tick();
      check_val($sformatf("cnt_e%0d_out", e), 32'(out0), 32'(e % 16));
      check_val($sformatf("cnt_e%0d_ovf", e), 32'(ovf0), (e == 16) ? 32'h1 : 32'h0);
    end
    tick();
    check_val("cnt_e17_out", 32'(out0), 32'h1);
    check_val("cnt_e17_ovf", 32'(ovf0), 32'h0);

    // LFSR.
    lfsr_exp[0] = 4'h0; lfsr_exp[1] = 4'h0; lfsr_exp[2] = 4'h1; lfsr_exp[3] = 4'h3;
    lfsr_exp[4] = 4'h7; lfsr_exp[5] = 4'hF; lfsr_exp[6] = 4'hE;
    do_reset(1'b1, 1'b0, 2'b10);
    for (int e = 0; e < 7; e++) begin
      tick();
      check_val($sformatf("lfsr_e%0d_out", e + 1), 32'(out0), 32'(lfsr_exp[e]));
      check_val($sformatf("lfsr_e%0d_ovf", e + 1), 32'(ovf0), 32'h0);
    end

    // Fill latency across parameter sets.
    do_reset(1'b0, 1'b0, 2'b00);
    for (int e = 1; e <= 6; e++) begin
      tick();
      check_val($sformatf("p1_valid_e%0d", e), 32'(valid1), 32'h1);
      check_val($sformatf("p5_valid_e%0d", e), 32'(valid2), (e >= 5) ? 32'h1 : 32'h0);
    end

    // Random sweep against the reference model.
    do_reset(1'b0, 1'b0, 2'b00);
    for (int cyc = 0; cyc < 1000; cyc++) begin
      a    = 1'($urandom_range(0, 1));
      b    = 1'($urandom_range(0, 1));
      mode = 2'($urandom_range(0, 3));
      m0 = mstep(m0, 2, 4, a, b, mode);
      m1 = mstep(m1, 1, 2, a, b, mode);
      m2 = mstep(m2, 5, 8, a, b, mode);
      tick();
      check_val($sformatf("rnd%0d_w4_out", cyc), 32'(out0), 32'(m0.ps[3:0]));
      check_val($sformatf("rnd%0d_w4_ovf", cyc), 32'(ovf0), 32'(m0.ovf));
      check_val($sformatf("rnd%0d_w2_out", cyc), 32'(out1), 32'(m1.ps[1:0]));
      check_val($sformatf("rnd%0d_w2_ovf", cyc), 32'(ovf1), 32'(m1.ovf));
      check_val($sformatf("rnd%0d_w2_valid", cyc), 32'(valid1), 32'(m1.fill == 4'd1));
      check_val($sformatf("rnd%0d_w8_out", cyc), 32'(out2), 32'(m2.ps));
      check_val($sformatf("rnd%0d_w8_ovf", cyc), 32'(ovf2), 32'(m2.ovf));
      check_val($sformatf("rnd%0d_w8_valid", cyc), 32'(valid2), 32'(m2.fill == 4'd5));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
